// File: rtl/axi_ad7124_regmap_if.sv
// Up-bus request/acknowledge bundle between up_axi (master) and the AD7124 register map (slave).
interface axi_ad7124_regmap_if;
  logic        up_wreq;
  logic [13:0] up_waddr;
  logic [31:0] up_wdata;
  logic        up_wack;
  logic        up_rreq;
  logic [13:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_rack;

  modport master (
    output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    input  up_wack, up_rdata, up_rack
  );

  modport slave (
    input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
    output up_wack, up_rdata, up_rack
  );
endinterface

// File: rtl/axi_ad7124_regmap.sv
// AD7124 acquisition register map: board/measurement controls, FIFO pop-on-read,
// sticky W1C interrupt status with enable mask and FIFO-level threshold.
module axi_ad7124_regmap #(
  parameter int unsigned NUM_OF_BOARD  = 6,
  parameter int unsigned FIFO_LVL_W    = 10,
  parameter logic [31:0] PCORE_VERSION = 32'h20201101,
  parameter logic [31:0] ID            = 32'd0
) (
  input  logic                    up_clk,
  input  logic                    up_rst,
  axi_ad7124_regmap_if.slave      up,
  output logic [NUM_OF_BOARD-1:0] ctrl_power_en,
  output logic [NUM_OF_BOARD-1:0] ctrl_relay_ctrl,
  output logic [NUM_OF_BOARD-1:0] ctrl_board_mask,
  output logic                    ctrl_reset,
  output logic                    ctrl_measure_immediate,
  output logic                    ctrl_measure_continuous,
  output logic [31:0]             ctrl_measure_count,
  input  logic [2:0]              stat_measure_state,
  input  logic                    stat_measure_done,
  output logic                    ctrl_fifo_read,
  input  logic [31:0]             stat_fifo_data,
  input  logic                    stat_fifo_empty,
  input  logic [FIFO_LVL_W-1:0]   stat_fifo_level,
  input  logic                    stat_fifo_overflow,
  output logic                    irq
);

  logic                    wack_q, rack_q;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             scratch_q;
  logic [NUM_OF_BOARD-1:0] power_en_q, relay_q, mask_q;
  logic                    reset_q, continuous_q, immediate_q, fifo_read_q;
  logic [31:0]             count_q;
  logic [2:0]              status_q, status_d, status_set, status_w1c, irq_en_q;
  logic [FIFO_LVL_W-1:0]   thresh_q;
  logic                    thr_hit, thr_q, irq_q;

  assign thr_hit    = (stat_fifo_level >= thresh_q) && (thresh_q != '0);
  assign status_set = {stat_fifo_overflow, thr_hit & ~thr_q, stat_measure_done};
  assign status_w1c = (up.up_wreq && up.up_waddr == 14'h38) ? up.up_wdata[2:0] : 3'd0;

  // Set has priority over a simultaneous write-one-to-clear.
  for (genvar gi = 0; gi < 3; gi++) begin : g_status
    assign status_d[gi] = status_set[gi] | (status_q[gi] & ~status_w1c[gi]);
  end

  always_comb begin
    rdata_d = '0;
    case (up.up_raddr)
      14'h00: rdata_d = PCORE_VERSION;
      14'h01: rdata_d = ID;
      14'h02: rdata_d = scratch_q;
      14'h03: rdata_d = {8'd0, 8'(FIFO_LVL_W), 8'd0, 8'(NUM_OF_BOARD)};
      14'h10: rdata_d = 32'(power_en_q);
      14'h11: rdata_d = 32'(relay_q);
      14'h20: rdata_d = {31'd0, reset_q};
      14'h21: rdata_d = 32'(mask_q);
      14'h29: rdata_d = {31'd0, continuous_q};
      14'h2A: rdata_d = count_q;
      14'h2B: rdata_d = {29'd0, stat_measure_state};
      14'h30: rdata_d = {16'(stat_fifo_level), 15'd0, stat_fifo_empty};
      14'h31: rdata_d = stat_fifo_empty ? 32'd0 : stat_fifo_data;
      14'h38: rdata_d = {29'd0, status_q};
      14'h39: rdata_d = {29'd0, irq_en_q};
      14'h3A: rdata_d = 32'(thresh_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      wack_q       <= 1'b0;
      rack_q       <= 1'b0;
      rdata_q      <= '0;
      scratch_q    <= '0;
      power_en_q   <= '0;
      relay_q      <= '0;
      mask_q       <= '0;
      reset_q      <= 1'b0;
      continuous_q <= 1'b0;
      immediate_q  <= 1'b0;
      fifo_read_q  <= 1'b0;
      count_q      <= '0;
      status_q     <= '0;
      irq_en_q     <= '0;
      thresh_q     <= '0;
      thr_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      wack_q      <= up.up_wreq;
      rack_q      <= up.up_rreq;
      immediate_q <= up.up_wreq && (up.up_waddr == 14'h28) && up.up_wdata[0];
      fifo_read_q <= up.up_rreq && (up.up_raddr == 14'h31) && !stat_fifo_empty;
      thr_q       <= thr_hit;
      status_q    <= status_d;
      irq_q       <= |(status_q & irq_en_q);
      if (up.up_rreq) rdata_q <= rdata_d;
      if (up.up_wreq) begin
        case (up.up_waddr)
          14'h02: scratch_q    <= up.up_wdata;
          14'h10: power_en_q   <= up.up_wdata[NUM_OF_BOARD-1:0];
          14'h11: relay_q      <= up.up_wdata[NUM_OF_BOARD-1:0];
          14'h20: reset_q      <= up.up_wdata[0];
          14'h21: mask_q       <= up.up_wdata[NUM_OF_BOARD-1:0];
          14'h29: continuous_q <= up.up_wdata[0];
          14'h2A: count_q      <= up.up_wdata;
          14'h39: irq_en_q     <= up.up_wdata[2:0];
          14'h3A: thresh_q     <= up.up_wdata[FIFO_LVL_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign up.up_wack              = wack_q;
  assign up.up_rack              = rack_q;
  assign up.up_rdata             = rdata_q;
  assign ctrl_power_en           = power_en_q;
  assign ctrl_relay_ctrl         = relay_q;
  assign ctrl_board_mask         = mask_q;
  assign ctrl_reset              = reset_q;
  assign ctrl_measure_immediate  = immediate_q;
  assign ctrl_measure_continuous = continuous_q;
  assign ctrl_measure_count      = count_q;
  assign ctrl_fifo_read          = fifo_read_q;
  assign irq                     = irq_q;

endmodule

// File: tb/tb_axi_ad7124_regmap.sv
// Scenario bench for axi_ad7124_regmap: expected read data queued at request, popped at rack.
module tb_axi_ad7124_regmap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  power_en, relay, mask;
  logic        ctrl_rst, imm, cont, fifo_rd, irq;
  logic [31:0] count;
  logic [2:0]  m_state = 3'd0;
  logic        m_done = 1'b0;
  logic [31:0] f_data = 32'd0;
  logic        f_empty = 1'b1;
  logic [9:0]  f_level = 10'd0;
  logic        f_ovf = 1'b0;

  int tests_run = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fifo_model[$];

  axi_ad7124_regmap_if up_if();

  axi_ad7124_regmap dut (
    .up_clk(clk), .up_rst(rst), .up(up_if),
    .ctrl_power_en(power_en), .ctrl_relay_ctrl(relay), .ctrl_board_mask(mask),
    .ctrl_reset(ctrl_rst), .ctrl_measure_immediate(imm), .ctrl_measure_continuous(cont),
    .ctrl_measure_count(count), .stat_measure_state(m_state), .stat_measure_done(m_done),
    .ctrl_fifo_read(fifo_rd), .stat_fifo_data(f_data), .stat_fifo_empty(f_empty),
    .stat_fifo_level(f_level), .stat_fifo_overflow(f_ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic up_read(input logic [13:0] a, output logic [31:0] d, output logic ack,
                         output logic pop);
    @(posedge clk); #1;
    up_if.up_rreq = 1'b1; up_if.up_raddr = a;
    @(posedge clk); #1;
    up_if.up_rreq = 1'b0;
    d = up_if.up_rdata; ack = up_if.up_rack; pop = fifo_rd;
    $display("[TB] rd addr=%h data=%h ack=%b pop=%b", a, d, ack, pop);
  endtask

  task automatic up_write(input logic [13:0] a, input logic [31:0] d, output logic ack);
    @(posedge clk); #1;
    up_if.up_wreq = 1'b1; up_if.up_waddr = a; up_if.up_wdata = d;
    @(posedge clk); #1;
    up_if.up_wreq = 1'b0;
    ack = up_if.up_wack;
    $display("[TB] wr addr=%h data=%h ack=%b", a, d, ack);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({irq, imm, fifo_rd, up_if.up_rack, up_if.up_wack} !== 5'b0 || up_if.up_rdata !== 32'd0
        || power_en !== 6'd0 || mask !== 6'd0 || count !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: irq=%b imm=%b rack=%b wack=%b rdata=%h pwr=%h cnt=%h required all 0",
                        irq, imm, up_if.up_rack, up_if.up_wack, up_if.up_rdata, power_en, count);
    end
    rst = 1'b0;
  endtask

  task automatic test_ids();
    logic [31:0] d; logic ack, pop, ack2;
    logic [13:0] addrs [4] = '{14'h00, 14'h01, 14'h03, 14'h3FF};
    logic [31:0] exps  [4] = '{32'h20201101, 32'd0, 32'h000A0006, 32'd0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exps[i]);
      up_read(addrs[i], d, ack, pop);
      tests_run++;
      if (ack !== 1'b1 || d !== exp_q.pop_front()) begin
        fails++; $display("FAIL id_read[%0d]: data=%h ack=%b required %h ack=1", i, d, ack, exps[i]);
      end
    end
    up_write(14'h002, 32'hCAFE_F00D, ack);
    up_write(14'h3FF, 32'h1234_5678, ack2);
    exp_q.push_back(32'hCAFE_F00D);
    up_read(14'h002, d, ack, pop);
    tests_run++;
    if (ack2 !== 1'b1 || d !== exp_q.pop_front()) begin
      fails++; $display("FAIL scratch: data=%h wack=%b required cafef00d wack=1", d, ack2);
    end
    // coincident read and write strobes
    @(posedge clk); #1;
    up_if.up_wreq = 1'b1; up_if.up_waddr = 14'h002; up_if.up_wdata = 32'h5555_AAAA;
    up_if.up_rreq = 1'b1; up_if.up_raddr = 14'h001;
    exp_q.push_back(32'd0);
    @(posedge clk); #1;
    up_if.up_wreq = 1'b0; up_if.up_rreq = 1'b0;
    tests_run++;
    if (up_if.up_wack !== 1'b1 || up_if.up_rack !== 1'b1 || up_if.up_rdata !== exp_q.pop_front()) begin
      fails++; $display("FAIL coincident: wack=%b rack=%b data=%h required 1 1 0",
                        up_if.up_wack, up_if.up_rack, up_if.up_rdata);
    end
    @(posedge clk); #1;
    tests_run++;
    if (up_if.up_wack !== 1'b0 || up_if.up_rack !== 1'b0) begin
      fails++; $display("FAIL ack_width: wack=%b rack=%b required 0 0", up_if.up_wack, up_if.up_rack);
    end
  endtask

  task automatic test_board_regs();
    logic [31:0] d; logic ack, pop;
    up_write(14'h010, 32'h0000_003F, ack);
    up_write(14'h021, 32'hFFFF_FFFF, ack);
    up_write(14'h011, 32'h0000_0115, ack);
    up_write(14'h02A, 32'h0000_1234, ack);
    tests_run++;
    if (power_en !== 6'h3F || mask !== 6'h3F || relay !== 6'h15 || count !== 32'h1234) begin
      fails++; $display("FAIL board_ctrl: pwr=%h mask=%h relay=%h cnt=%h required 3f 3f 15 1234",
                        power_en, mask, relay, count);
    end
    exp_q.push_back(32'h3F);
    up_read(14'h021, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL mask_read: data=%h required 3f", d);
    end
    m_state = 3'd5;
    exp_q.push_back(32'd5);
    up_read(14'h02B, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL state_read: data=%h required 5", d);
    end
  endtask

  task automatic test_fifo();
    logic [31:0] d; logic ack, pop, exp_pop;
    fifo_model = '{32'hA, 32'hB};
    f_data = fifo_model[0]; f_empty = 1'b0; f_level = 10'd2;
    exp_q.push_back(32'h0002_0000);
    up_read(14'h030, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL fifo_stat: data=%h required 00020000", d);
    end
    for (int i = 0; i < 3; i++) begin
      exp_pop = (fifo_model.size() != 0);
      exp_q.push_back(exp_pop ? fifo_model[0] : 32'd0);
      up_read(14'h031, d, ack, pop);
      tests_run++;
      if (d !== exp_q.pop_front() || pop !== exp_pop) begin
        fails++; $display("FAIL fifo_pop[%0d]: data=%h pop=%b required pop=%b", i, d, pop, exp_pop);
      end
      if (exp_pop) void'(fifo_model.pop_front());
      f_level = 10'(fifo_model.size());
      f_empty = (fifo_model.size() == 0);
      f_data  = f_empty ? 32'hDEAD_BEEF : fifo_model[0];
    end
    f_level = 10'd0;
  endtask

  task automatic test_irq_done();
    logic [31:0] d; logic ack, pop;
    up_write(14'h039, 32'h1, ack);
    @(posedge clk); #1; m_done = 1'b1;
    @(posedge clk); #1; m_done = 1'b0;
    tests_run++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_latency1: irq=%b required 0", irq);
    end
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL irq_latency2: irq=%b required 1", irq);
    end
    @(posedge clk); #1;
    up_if.up_wreq = 1'b1; up_if.up_waddr = 14'h038; up_if.up_wdata = 32'h1; m_done = 1'b1;
    @(posedge clk); #1;
    up_if.up_wreq = 1'b0; m_done = 1'b0;
    exp_q.push_back(32'h1);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front() || irq !== 1'b1) begin
      fails++; $display("FAIL set_wins: status=%h irq=%b required 1 1", d, irq);
    end
    up_write(14'h038, 32'h1, ack);
    exp_q.push_back(32'h0);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front() || irq !== 1'b0) begin
      fails++; $display("FAIL w1c_done: status=%h irq=%b required 0 0", d, irq);
    end
  endtask

  task automatic test_thresh();
    logic [31:0] d; logic ack, pop;
    f_level = 10'd3;
    up_write(14'h03A, 32'h4, ack);
    repeat (2) @(posedge clk);
    exp_q.push_back(32'h0);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL below_thresh: status=%h required 0", d);
    end
    f_level = 10'd4;
    repeat (2) @(posedge clk);
    exp_q.push_back(32'h2);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL thresh_edge: status=%h required 2", d);
    end
    f_level = 10'd5;
    up_write(14'h038, 32'h2, ack);
    repeat (3) @(posedge clk);
    exp_q.push_back(32'h0);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL thresh_hold: status=%h required 0", d);
    end
    @(posedge clk); #1; f_ovf = 1'b1;
    @(posedge clk); #1; f_ovf = 1'b0;
    exp_q.push_back(32'h4);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL overflow: status=%h required 4", d);
    end
  endtask

  task automatic test_start_reset();
    logic [31:0] d; logic ack, pop;
    up_write(14'h028, 32'h1, ack);
    tests_run++;
    if (imm !== 1'b1) begin
      fails++; $display("FAIL start_pulse: imm=%b required 1", imm);
    end
    @(posedge clk); #1;
    tests_run++;
    if (imm !== 1'b0) begin
      fails++; $display("FAIL start_single: imm=%b required 0", imm);
    end
    exp_q.push_back(32'h0);
    up_read(14'h028, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL start_read: data=%h required 0", d);
    end
    up_write(14'h039, 32'h4, ack);
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL ovf_irq: irq=%b required 1", irq);
    end
    up_write(14'h028, 32'h1, ack);
    rst = 1'b1;
    tests_run++;
    if (imm !== 1'b1) begin
      fails++; $display("FAIL pre_reset_pulse: imm=%b required 1", imm);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (imm !== 1'b0 || irq !== 1'b0 || power_en !== 6'd0 || mask !== 6'd0 || count !== 32'd0) begin
      fails++; $display("FAIL mid_reset: imm=%b irq=%b pwr=%h mask=%h cnt=%h required all 0",
                        imm, irq, power_en, mask, count);
    end
    exp_q.push_back(32'h0);
    up_read(14'h038, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL reset_status: data=%h required 0", d);
    end
    exp_q.push_back(32'h0);
    up_read(14'h03A, d, ack, pop);
    tests_run++;
    if (d !== exp_q.pop_front()) begin
      fails++; $display("FAIL reset_thresh: data=%h required 0", d);
    end
  endtask

  initial begin
    up_if.up_wreq = 1'b0; up_if.up_waddr = '0; up_if.up_wdata = '0;
    up_if.up_rreq = 1'b0; up_if.up_raddr = '0;
    test_reset();
    test_ids();
    test_board_regs();
    test_fifo();
    test_irq_done();
    test_thresh();
    test_start_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
